// File: rtl/armleocpu_mem_arbiter_pkg.sv
// Shared encodings for the armleocpu memory arbiter: bus responses, commands
// and arbiter FSM states.
package armleocpu_mem_arbiter_pkg;

   localparam logic [2:0] RESP_OKAY        = 3'd0;
   localparam logic [2:0] RESP_SLVERR      = 3'd1;
   localparam logic [2:0] RESP_DECERR      = 3'd2;
   localparam logic [2:0] RESP_INVALID_CMD = 3'd3;

   localparam logic [2:0] CMD_NONE        = 3'd0;
   localparam logic [2:0] CMD_READ        = 3'd1;
   localparam logic [2:0] CMD_WRITE       = 3'd2;
   localparam logic [2:0] CMD_BURST_READ  = 3'd3;
   localparam logic [2:0] CMD_BURST_WRITE = 3'd4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GNT_D = 2'd1,
      ARB_GNT_I = 2'd2
   } arb_state_t;

   // A burstcount of zero still moves one beat.
   function automatic logic [3:0] beats_of(input logic [3:0] burstcount);
      return (burstcount == 4'd0) ? 4'd1 : burstcount;
   endfunction

endpackage

// File: rtl/armleocpu_rr_arbiter2.sv
// Two-way requester pick (round-robin or fixed D priority) with the
// last-grant history register; bit0 = D, bit1 = I.
module armleocpu_rr_arbiter2 #(
   parameter int   PRIORITY_MODE    = 0,
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] pick
);

   // 0: D was granted last, 1: I was granted last.
   logic last_grant;

   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         if ((PRIORITY_MODE != 0) || last_grant)
            pick = 2'b01;
         else
            pick = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= RESET_LAST_GRANT;
      else if (take && (pick != 2'b00))
         last_grant <= pick[1];
   end

endmodule

// File: rtl/armleocpu_mem_arbiter.sv
// Merges the armleocpu D-cache and I-cache master ports onto one memory port,
// holding each grant for a whole (possibly burst) transaction.
module armleocpu_mem_arbiter
   import armleocpu_mem_arbiter_pkg::*;
#(
   parameter int   PRIORITY_MODE    = 0,
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        d_transaction,
   input  logic [2:0]  d_cmd,
   input  logic [33:0] d_address,
   input  logic [3:0]  d_burstcount,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wbyte_enable,
   output logic        d_transaction_done,
   output logic [2:0]  d_transaction_response,
   output logic [31:0] d_rdata,

   input  logic        i_transaction,
   input  logic [2:0]  i_cmd,
   input  logic [33:0] i_address,
   input  logic [3:0]  i_burstcount,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wbyte_enable,
   output logic        i_transaction_done,
   output logic [2:0]  i_transaction_response,
   output logic [31:0] i_rdata,

   output logic        m_transaction,
   output logic [2:0]  m_cmd,
   output logic [33:0] m_address,
   output logic [3:0]  m_burstcount,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wbyte_enable,
   input  logic        m_transaction_done,
   input  logic [2:0]  m_transaction_response,
   input  logic [31:0] m_rdata,

   output logic [1:0]  grant
);

   // Handshake: a master holds x_transaction with stable command fields until
   // its final done; every x_transaction_done is one completed beat, and a
   // non-OKAY response ends the transaction at that beat.

   arb_state_t state, state_nxt;
   logic [3:0] remaining, remaining_nxt;
   logic [1:0] pick;
   logic       take;

   armleocpu_rr_arbiter2 #(
      .PRIORITY_MODE    (PRIORITY_MODE),
      .RESET_LAST_GRANT (RESET_LAST_GRANT)
   ) u_pick (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({i_transaction, d_transaction}),
      .take  (take),
      .pick  (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         remaining <= 4'd0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
      end
   end

   always_comb begin
      state_nxt              = state;
      remaining_nxt          = remaining;
      take                   = 1'b0;
      grant                  = 2'b00;
      m_transaction          = 1'b0;
      m_cmd                  = 3'd0;
      m_address              = 34'd0;
      m_burstcount           = 4'd0;
      m_wdata                = 32'd0;
      m_wbyte_enable         = 4'd0;
      d_transaction_done     = 1'b0;
      d_transaction_response = 3'd0;
      i_transaction_done     = 1'b0;
      i_transaction_response = 3'd0;
      d_rdata                = m_rdata;
      i_rdata                = m_rdata;

      case (state)
         ARB_IDLE: begin
            // Grant takes effect next cycle, so m_* never sees a raw request.
            take = 1'b1;
            if (pick[0]) begin
               state_nxt     = ARB_GNT_D;
               remaining_nxt = beats_of(d_burstcount);
            end else if (pick[1]) begin
               state_nxt     = ARB_GNT_I;
               remaining_nxt = beats_of(i_burstcount);
            end
         end

         ARB_GNT_D, ARB_GNT_I: begin
            if (state == ARB_GNT_D) begin
               grant                  = 2'b01;
               m_transaction          = d_transaction;
               m_cmd                  = d_cmd;
               m_address              = d_address;
               m_burstcount           = d_burstcount;
               m_wdata                = d_wdata;
               m_wbyte_enable         = d_wbyte_enable;
               d_transaction_done     = m_transaction_done;
               d_transaction_response = m_transaction_response;
            end else begin
               grant                  = 2'b10;
               m_transaction          = i_transaction;
               m_cmd                  = i_cmd;
               m_address              = i_address;
               m_burstcount           = i_burstcount;
               m_wdata                = i_wdata;
               m_wbyte_enable         = i_wbyte_enable;
               i_transaction_done     = m_transaction_done;
               i_transaction_response = m_transaction_response;
            end

            if (m_transaction_done) begin
               remaining_nxt = remaining - 4'd1;
               if ((remaining == 4'd1) || (m_transaction_response != RESP_OKAY)) begin
                  state_nxt     = ARB_IDLE;
                  remaining_nxt = 4'd0;
               end
            end
         end

         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
// Bench for armleocpu_mem_arbiter: directed test-plan steps plus randomized
// traffic, both checked every cycle against a behavioural arbitration model.
module tb_armleocpu_mem_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_rr, rst_n_fp;
   logic sel;  // 0: round-robin instance observed, 1: fixed-priority instance

   // ---------------- shared stimulus ----------------
   logic        d_transaction, i_transaction;
   logic [2:0]  d_cmd, i_cmd;
   logic [33:0] d_address, i_address;
   logic [3:0]  d_burstcount, i_burstcount;
   logic [31:0] d_wdata, i_wdata;
   logic [3:0]  d_wbyte_enable, i_wbyte_enable;
   logic        m_done;
   logic [2:0]  m_resp;
   logic [31:0] m_rdata;

   // ---------------- per-instance outputs ----------------
   logic [1:0]  o_d_done, o_i_done, o_m_tr;
   logic [2:0]  o_d_resp [2];
   logic [2:0]  o_i_resp [2];
   logic [31:0] o_d_rdata [2];
   logic [31:0] o_i_rdata [2];
   logic [2:0]  o_m_cmd [2];
   logic [33:0] o_m_addr [2];
   logic [3:0]  o_m_bc [2];
   logic [31:0] o_m_wdata [2];
   logic [3:0]  o_m_be [2];
   logic [1:0]  o_grant [2];

   armleocpu_mem_arbiter #(.PRIORITY_MODE(0), .RESET_LAST_GRANT(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n_rr),
      .d_transaction(d_transaction), .d_cmd(d_cmd), .d_address(d_address),
      .d_burstcount(d_burstcount), .d_wdata(d_wdata), .d_wbyte_enable(d_wbyte_enable),
      .d_transaction_done(o_d_done[0]), .d_transaction_response(o_d_resp[0]), .d_rdata(o_d_rdata[0]),
      .i_transaction(i_transaction), .i_cmd(i_cmd), .i_address(i_address),
      .i_burstcount(i_burstcount), .i_wdata(i_wdata), .i_wbyte_enable(i_wbyte_enable),
      .i_transaction_done(o_i_done[0]), .i_transaction_response(o_i_resp[0]), .i_rdata(o_i_rdata[0]),
      .m_transaction(o_m_tr[0]), .m_cmd(o_m_cmd[0]), .m_address(o_m_addr[0]),
      .m_burstcount(o_m_bc[0]), .m_wdata(o_m_wdata[0]), .m_wbyte_enable(o_m_be[0]),
      .m_transaction_done(m_done), .m_transaction_response(m_resp), .m_rdata(m_rdata),
      .grant(o_grant[0])
   );

   armleocpu_mem_arbiter #(.PRIORITY_MODE(1), .RESET_LAST_GRANT(1'b1)) u_fp (
      .clk(clk), .rst_n(rst_n_fp),
      .d_transaction(d_transaction), .d_cmd(d_cmd), .d_address(d_address),
      .d_burstcount(d_burstcount), .d_wdata(d_wdata), .d_wbyte_enable(d_wbyte_enable),
      .d_transaction_done(o_d_done[1]), .d_transaction_response(o_d_resp[1]), .d_rdata(o_d_rdata[1]),
      .i_transaction(i_transaction), .i_cmd(i_cmd), .i_address(i_address),
      .i_burstcount(i_burstcount), .i_wdata(i_wdata), .i_wbyte_enable(i_wbyte_enable),
      .i_transaction_done(o_i_done[1]), .i_transaction_response(o_i_resp[1]), .i_rdata(o_i_rdata[1]),
      .m_transaction(o_m_tr[1]), .m_cmd(o_m_cmd[1]), .m_address(o_m_addr[1]),
      .m_burstcount(o_m_bc[1]), .m_wdata(o_m_wdata[1]), .m_wbyte_enable(o_m_be[1]),
      .m_transaction_done(m_done), .m_transaction_response(m_resp), .m_rdata(m_rdata),
      .grant(o_grant[1])
   );

   // ---------------- scoreboard counters ----------------
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Owner of the memory port (0 none, 1 D, 2 I), beats still owed, and
   // whether I was the most recent winner.
   int exp_owner;
   int exp_left;
   bit exp_last_i;
   bit cmpl_d, cmpl_i;

   task automatic model_reset();
      exp_owner  = 0;
      exp_left   = 0;
      exp_last_i = 1'b1;
   endtask

   task automatic model_clock();
      int w;
      cmpl_d = 1'b0;
      cmpl_i = 1'b0;
      if (exp_owner == 0) begin
         if (d_transaction && i_transaction) w = (sel || exp_last_i) ? 1 : 2;
         else if (d_transaction) w = 1;
         else if (i_transaction) w = 2;
         else w = 0;
         if (w != 0) begin
            exp_owner  = w;
            exp_left   = (w == 1) ? int'(d_burstcount) : int'(i_burstcount);
            if (exp_left == 0) exp_left = 1;
            exp_last_i = (w == 2);
         end
      end else if (m_done) begin
         exp_left--;
         if (exp_left == 0 || m_resp != 3'd0) begin
            if (exp_owner == 1) cmpl_d = 1'b1;
            else cmpl_i = 1'b1;
            exp_owner = 0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [77:0] mexp;
      logic [1:0]  gexp;
      logic [35:0] dexp, iexp;
      mexp = '0;
      gexp = 2'b00;
      dexp = {1'b0, 3'd0, m_rdata};
      iexp = {1'b0, 3'd0, m_rdata};
      if (exp_owner == 1) begin
         gexp = 2'b01;
         mexp = {d_transaction, d_cmd, d_address, d_burstcount, d_wdata, d_wbyte_enable};
         dexp = {m_done, m_resp, m_rdata};
      end else if (exp_owner == 2) begin
         gexp = 2'b10;
         mexp = {i_transaction, i_cmd, i_address, i_burstcount, i_wdata, i_wbyte_enable};
         iexp = {m_done, m_resp, m_rdata};
      end
      check("grant", 128'(o_grant[sel]), 128'(gexp));
      check("m_req", 128'({o_m_tr[sel], o_m_cmd[sel], o_m_addr[sel], o_m_bc[sel],
                           o_m_wdata[sel], o_m_be[sel]}), 128'(mexp));
      check("d_rsp", 128'({o_d_done[sel], o_d_resp[sel], o_d_rdata[sel]}), 128'(dexp));
      check("i_rsp", 128'({o_i_done[sel], o_i_resp[sel], o_i_rdata[sel]}), 128'(iexp));
   endtask

   // One clock: check settled outputs, advance the model at the edge, return
   // at the falling edge ready for the next input change.
   task automatic step();
      #1 check_outputs();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_d(input logic [3:0] bc, input logic [2:0] cmd);
      d_transaction  = 1'b1;
      d_cmd          = cmd;
      d_address      = {2'($urandom_range(0, 3)), 32'($urandom)};
      d_burstcount   = bc;
      d_wdata        = $urandom;
      d_wbyte_enable = 4'($urandom_range(0, 15));
   endtask

   task automatic set_i(input logic [3:0] bc, input logic [2:0] cmd);
      i_transaction  = 1'b1;
      i_cmd          = cmd;
      i_address      = {2'($urandom_range(0, 3)), 32'($urandom)};
      i_burstcount   = bc;
      i_wdata        = $urandom;
      i_wbyte_enable = 4'($urandom_range(0, 15));
   endtask

   task automatic mem(input logic done, input logic [2:0] resp);
      m_done  = done;
      m_resp  = resp;
      m_rdata = $urandom;
   endtask

   task automatic random_traffic(input int cycles);
      bit d_active, i_active;
      d_active = 1'b0;
      i_active = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         if (!d_active && $urandom_range(0, 2) == 0) begin
            d_active = 1'b1;
            set_d(4'($urandom_range(0, 15)), 3'($urandom_range(1, 4)));
         end
         if (!i_active && $urandom_range(0, 2) == 0) begin
            i_active = 1'b1;
            set_i(4'($urandom_range(0, 15)), 3'($urandom_range(1, 4)));
         end
         d_wdata = $urandom;
         i_wdata = $urandom;
         mem(1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
         step();
         if (cmpl_d) begin d_active = 1'b0; d_transaction = 1'b0; end
         if (cmpl_i) begin i_active = 1'b0; i_transaction = 1'b0; end
      end
      d_transaction = 1'b0;
      i_transaction = 1'b0;
      mem(1'b0, 3'd0);
      // Drain whatever grant is still open so the next phase starts in IDLE.
      for (int k = 0; k < 4 && exp_owner != 0; k++) begin
         mem(1'b1, 3'd1);
         step();
      end
      mem(1'b0, 3'd0);
      step();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int beats;
      rst_n_rr = 1'b0;
      rst_n_fp = 1'b0;
      sel = 1'b0;
      d_transaction = 0; d_cmd = 0; d_address = 0; d_burstcount = 0; d_wdata = 0; d_wbyte_enable = 0;
      i_transaction = 0; i_cmd = 0; i_address = 0; i_burstcount = 0; i_wdata = 0; i_wbyte_enable = 0;
      m_done = 0; m_resp = 0; m_rdata = 0;
      model_reset();

      repeat (3) @(negedge clk);
      set_d(4'd1, 3'd1);
      #1 check("reset_grant", 128'(o_grant[0]), 128'(2'b00));
      check("reset_m_tr", 128'(o_m_tr[0]), 128'(1'b0));
      d_transaction = 1'b0;
      @(negedge clk);
      rst_n_rr = 1'b1;
      @(negedge clk);

      // 1: D single beat, memory answers on the third granted cycle.
      set_d(4'd1, 3'd1);
      #1 check("t1_m_tr_before", 128'(o_m_tr[0]), 128'(1'b0));
      step();
      check("t1_grant", 128'(o_grant[0]), 128'(2'b01));
      check("t1_m_tr_after", 128'(o_m_tr[0]), 128'(1'b1));
      step();
      step();
      mem(1'b1, 3'd0);
      #1 check("t1_i_done", 128'(o_i_done[0]), 128'(1'b0));
      step();
      d_transaction = 1'b0;
      mem(1'b0, 3'd0);
      check("t1_release", 128'(o_grant[0]), 128'(2'b00));
      step();

      // 2: simultaneous request right after reset, D first then I.
      rst_n_rr = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n_rr = 1'b1;
      set_d(4'd1, 3'd1);
      set_i(4'd1, 3'd1);
      step();
      check("t2_first_d", 128'(o_grant[0]), 128'(2'b01));
      mem(1'b1, 3'd0);
      step();
      d_transaction = 1'b0;
      mem(1'b0, 3'd0);
      check("t2_dead_cycle", 128'(o_grant[0]), 128'(2'b00));
      step();
      check("t2_then_i", 128'(o_grant[0]), 128'(2'b10));
      mem(1'b1, 3'd0);
      step();
      i_transaction = 1'b0;
      mem(1'b0, 3'd0);
      step();

      // 3: I burst of 4, D arrives mid-burst and waits for the dead cycle.
      set_i(4'd4, 3'd3);
      step();
      mem(1'b1, 3'd0);
      step();
      set_d(4'd1, 3'd1);
      step();
      check("t3_hold_i", 128'(o_grant[0]), 128'(2'b10));
      check("t3_d_done", 128'(o_d_done[0]), 128'(1'b0));
      step();
      step();
      i_transaction = 1'b0;
      mem(1'b0, 3'd0);
      check("t3_dead_cycle", 128'(o_grant[0]), 128'(2'b00));
      step();
      check("t3_d_after", 128'(o_grant[0]), 128'(2'b01));
      mem(1'b1, 3'd0);
      step();
      d_transaction = 1'b0;
      mem(1'b0, 3'd0);
      step();

      // 4: D write burst of 8 aborted by an error on beat 3.
      set_d(4'd8, 3'd4);
      step();
      mem(1'b1, 3'd0);
      step();
      step();
      mem(1'b1, 3'd3);
      #1 check("t4_err_fwd", 128'(o_d_resp[0]), 128'(3'd3));
      step();
      mem(1'b0, 3'd0);
      check("t4_released", 128'(o_grant[0]), 128'(2'b00));
      d_transaction = 1'b0;
      step();

      // Granted master drops its request early; grant must be held.
      set_d(4'd2, 3'd3);
      step();
      d_transaction = 1'b0;
      step();
      check("drop_hold", 128'(o_grant[0]), 128'(2'b01));
      check("drop_m_tr", 128'(o_m_tr[0]), 128'(1'b0));
      mem(1'b1, 3'd0);
      step();
      step();
      mem(1'b0, 3'd0);
      step();

      // Memory done while idle must not leak to either master.
      mem(1'b1, 3'd0);
      #1 check("idle_done_d", 128'(o_d_done[0]), 128'(1'b0));
      step();
      mem(1'b0, 3'd0);

      // 5: asynchronous reset in the middle of a 4-beat burst.
      set_i(4'd1, 3'd1);
      step();
      i_transaction = 1'b0;
      mem(1'b1, 3'd0);
      step();
      mem(1'b0, 3'd0);
      set_d(4'd4, 3'd3);
      step();
      mem(1'b1, 3'd0);
      step();
      #2 rst_n_rr = 1'b0;
      #1 check("t5_grant_async", 128'(o_grant[0]), 128'(2'b00));
      check("t5_m_tr_async", 128'(o_m_tr[0]), 128'(1'b0));
      model_reset();
      d_transaction = 1'b0;
      mem(1'b0, 3'd0);
      @(negedge clk);
      rst_n_rr = 1'b1;
      set_d(4'd1, 3'd1);
      set_i(4'd1, 3'd1);
      step();
      check("t5_last_grant_reset", 128'(o_grant[0]), 128'(2'b01));
      d_transaction = 1'b0;
      i_transaction = 1'b0;
      mem(1'b1, 3'd0);
      step();
      mem(1'b0, 3'd0);
      step();

      random_traffic(1500);

      // 6: fixed D priority instance.
      rst_n_rr = 1'b0;
      rst_n_fp = 1'b1;
      sel = 1'b1;
      model_reset();
      @(negedge clk);
      set_d(4'd0, 3'd1);
      set_i(4'd1, 3'd1);
      for (int n = 0; n < 4; n++) begin
         step();
         check("t6_d_wins", 128'(o_grant[1]), 128'(2'b01));
         mem(1'b1, 3'd0);
         step();
         mem(1'b0, 3'd0);
         check("t6_bc0_single", 128'(o_grant[1]), 128'(2'b00));
      end
      set_d(4'd15, 3'd3);
      step();
      mem(1'b1, 3'd0);
      beats = 0;
      for (int k = 0; k < 40 && o_grant[1] != 2'b00; k++) begin
         #1 if (o_d_done[1]) beats++;
         step();
      end
      check("t6_bc15_beats", 128'(beats), 128'(15));
      d_transaction = 1'b0;
      mem(1'b0, 3'd0);
      step();
      check("t6_i_served", 128'(o_grant[1]), 128'(2'b10));
      mem(1'b1, 3'd0);
      step();
      i_transaction = 1'b0;
      mem(1'b0, 3'd0);
      step();

      random_traffic(800);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
